// File: rtl/load_extend_unit_if.sv
// Load-response / writeback handshake bundle for load_extend_unit.
// The master drives load responses and consumes results. The slave is the formatter.
interface load_extend_unit_if;
  logic        in_valid;
  logic        in_ready;
  logic [2:0]  op;
  logic [1:0]  addr_lo;
  logic [31:0] mem_word;
  logic [31:0] rt_old;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_data;
  logic        out_exc;

  modport master (
    output in_valid, op, addr_lo, mem_word, rt_old, out_ready,
    input  in_ready, out_valid, out_data, out_exc
  );

  modport slave (
    input  in_valid, op, addr_lo, mem_word, rt_old, out_ready,
    output in_ready, out_valid, out_data, out_exc
  );
endinterface

// File: rtl/load_extend_unit.sv
// MIPS load-data formatter: lane extract, sign/zero extend, LWL/LWR merge,
// exception flagging, and a small output FIFO with a saturating exception counter.
module load_extend_unit #(
  parameter int DEPTH = 2,
  parameter int CNT_W = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  load_extend_unit_if.slave    bus,
  input  logic                 cnt_clr,
  output logic [CNT_W-1:0]     exc_count
);
  localparam int AW = $clog2(DEPTH);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;
  logic [4:0]  shl;
  logic [4:0]  shr;
  logic [31:0] fmt_data;
  logic        fmt_exc;

  logic [32:0]   mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [AW-1:0] rd_next;
  logic [AW:0]   count;
  logic [AW:0]   count_next;
  logic          push;
  logic          pop;

  always_comb begin
    byte_sel = 8'h00;
    case (bus.addr_lo)
      2'd0: byte_sel = bus.mem_word[7:0];
      2'd1: byte_sel = bus.mem_word[15:8];
      2'd2: byte_sel = bus.mem_word[23:16];
      2'd3: byte_sel = bus.mem_word[31:24];
      default: byte_sel = 8'h00;
    endcase
    half_sel = bus.addr_lo[1] ? bus.mem_word[31:16] : bus.mem_word[15:0];
    shl      = {2'd3 - bus.addr_lo, 3'b000};
    shr      = {bus.addr_lo, 3'b000};
    fmt_data = 32'h0;
    fmt_exc  = 1'b0;
    case (bus.op)
      3'd0: fmt_data = {{24{byte_sel[7]}}, byte_sel};
      3'd4: fmt_data = {24'h0, byte_sel};
      3'd1: begin
        fmt_data = {{16{half_sel[15]}}, half_sel};
        fmt_exc  = bus.addr_lo[0];
      end
      3'd5: begin
        fmt_data = {16'h0, half_sel};
        fmt_exc  = bus.addr_lo[0];
      end
      3'd3: begin
        fmt_data = bus.mem_word;
        fmt_exc  = (bus.addr_lo != 2'd0);
      end
      3'd2: fmt_data = (bus.mem_word << shl) | (bus.rt_old & ~(32'hFFFF_FFFF << shl));
      3'd6: fmt_data = (bus.mem_word >> shr) | (bus.rt_old & ~(32'hFFFF_FFFF >> shr));
      default: fmt_exc = 1'b1;
    endcase
    // Exception entries carry zero data so nothing stale reaches writeback.
    if (fmt_exc) fmt_data = 32'h0;
  end

  assign bus.in_ready  = (count != (AW+1)'(DEPTH));
  assign bus.out_valid = (count != '0);
  assign push = bus.in_valid && bus.in_ready;
  assign pop  = bus.out_valid && bus.out_ready;

  always_comb begin
    rd_next    = pop ? rd_ptr + AW'(1) : rd_ptr;
    count_next = count + (AW+1)'(push) - (AW+1)'(pop);
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= {fmt_exc, fmt_data};
  end

  // The head is re-registered each cycle; a push into an otherwise empty queue bypasses storage.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr       <= '0;
      rd_ptr       <= '0;
      count        <= '0;
      bus.out_data <= 32'h0;
      bus.out_exc  <= 1'b0;
      exc_count    <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      rd_ptr <= rd_next;
      count  <= count_next;
      if (count_next != '0) begin
        if (push && (wr_ptr == rd_next)) begin
          bus.out_data <= fmt_data;
          bus.out_exc  <= fmt_exc;
        end else begin
          bus.out_data <= mem[rd_next][31:0];
          bus.out_exc  <= mem[rd_next][32];
        end
      end
      if (push && fmt_exc) begin
        if (cnt_clr)
          exc_count <= CNT_W'(1);
        else if (exc_count != {CNT_W{1'b1}})
          exc_count <= exc_count + CNT_W'(1);
      end else if (cnt_clr) begin
        exc_count <= '0;
      end
    end
  end
endmodule

// File: tb/tb_load_extend_unit.sv
// Self-checking bench for load_extend_unit (DEPTH=2, CNT_W=2): vector table,
// hand-written backpressure/saturation/reset sequences, and a randomized model check.
module tb_load_extend_unit;
  logic       clk;
  logic       rst_n;
  logic       cnt_clr;
  logic [1:0] exc_count;
  int         checks;
  int         errors;

  load_extend_unit_if bus ();

  load_extend_unit #(.DEPTH(2), .CNT_W(2)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .bus       (bus.slave),
    .cnt_clr   (cnt_clr),
    .exc_count (exc_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [2:0]  op;
    logic [1:0]  k;
    logic [31:0] mem;
    logic [31:0] rt;
    logic [31:0] data;
    logic        exc;
    int          cnt;
  } vec_t;

  vec_t tbl[12];

  typedef struct {
    logic [31:0] data;
    logic        exc;
  } entry_t;

  entry_t q[$];

  // Byte-lane description of the load family, independent of shift/mask formulation.
  function automatic logic [32:0] refFormat(input int op, input int k,
                                            input logic [31:0] mw, input logic [31:0] rt);
    logic [7:0] mb[4];
    logic [7:0] rb[4];
    logic [7:0] res[4];
    int b;
    int h;
    for (int i = 0; i < 4; i++) begin
      mb[i] = mw[8*i +: 8];
      rb[i] = rt[8*i +: 8];
    end
    case (op)
      0: begin b = mb[k]; if (b >= 128) b = b - 256; return {1'b0, 32'(b)}; end
      4: return {1'b0, 32'(mb[k])};
      1, 5: begin
        if (k % 2 == 1) return {1'b1, 32'h0};
        h = int'(mb[k+1]) * 256 + int'(mb[k]);
        if (op == 1 && h >= 32768) h = h - 65536;
        return {1'b0, 32'(h)};
      end
      3: begin
        if (k != 0) return {1'b1, 32'h0};
        return {1'b0, mw};
      end
      2: begin
        for (int i = 0; i < 4; i++)
          if (i >= 3 - k) res[i] = mb[i - (3 - k)];
          else res[i] = rb[i];
        return {1'b0, res[3], res[2], res[1], res[0]};
      end
      6: begin
        for (int i = 0; i < 4; i++)
          if (i <= 3 - k) res[i] = mb[i + k];
          else res[i] = rb[i];
        return {1'b0, res[3], res[2], res[1], res[0]};
      end
      default: return {1'b1, 32'h0};
    endcase
  endfunction

  task automatic applyStimulus(input logic valid, input logic [2:0] op, input logic [1:0] k,
                               input logic [31:0] mw, input logic [31:0] rt, input logic clr);
    bus.in_valid = valid;
    bus.op       = op;
    bus.addr_lo  = k;
    bus.mem_word = mw;
    bus.rt_old   = rt;
    cnt_clr      = clr;
  endtask

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, actual, expected);
    end
  endtask

  localparam logic [31:0] MW = 32'h8091A2F3;
  localparam logic [31:0] RT = 32'h11223344;

  initial begin
    logic [32:0] r;
    int mcnt;
    bit push;
    bit pop;
    bit exc;
    checks = 0;
    errors = 0;

    tbl[0]  = '{3'd0, 2'd0, MW, RT, 32'hFFFFFFF3, 1'b0, 0};
    tbl[1]  = '{3'd4, 2'd3, MW, RT, 32'h00000080, 1'b0, 0};
    tbl[2]  = '{3'd1, 2'd2, MW, RT, 32'hFFFF8091, 1'b0, 0};
    tbl[3]  = '{3'd5, 2'd0, MW, RT, 32'h0000A2F3, 1'b0, 0};
    tbl[4]  = '{3'd3, 2'd0, MW, RT, 32'h8091A2F3, 1'b0, 0};
    tbl[5]  = '{3'd2, 2'd1, MW, RT, 32'hA2F33344, 1'b0, 0};
    tbl[6]  = '{3'd6, 2'd2, MW, RT, 32'h11228091, 1'b0, 0};
    tbl[7]  = '{3'd2, 2'd3, MW, RT, 32'h8091A2F3, 1'b0, 0};
    tbl[8]  = '{3'd6, 2'd0, MW, RT, 32'h8091A2F3, 1'b0, 0};
    tbl[9]  = '{3'd1, 2'd1, MW, RT, 32'h00000000, 1'b1, 1};
    tbl[10] = '{3'd3, 2'd2, MW, RT, 32'h00000000, 1'b1, 2};
    tbl[11] = '{3'd7, 2'd0, MW, RT, 32'h00000000, 1'b1, 3};

    // Reset state
    rst_n = 1'b0;
    bus.out_ready = 1'b1;
    applyStimulus(1'b0, 3'd0, 2'd0, 32'h0, 32'h0, 1'b0);
    #12;
    checkOutput("rst_out_valid", 32'(bus.out_valid), 32'd0);
    checkOutput("rst_in_ready", 32'(bus.in_ready), 32'd1);
    checkOutput("rst_out_data", bus.out_data, 32'h0);
    checkOutput("rst_out_exc", 32'(bus.out_exc), 32'd0);
    checkOutput("rst_exc_count", 32'(exc_count), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // Vector table, one load per cycle with a ready consumer
    for (int i = 0; i < 12; i++) begin
      applyStimulus(1'b1, tbl[i].op, tbl[i].k, tbl[i].mem, tbl[i].rt, 1'b0);
      @(negedge clk);
      checkOutput($sformatf("vec%0d_valid", i), 32'(bus.out_valid), 32'd1);
      checkOutput($sformatf("vec%0d_data", i), bus.out_data, tbl[i].data);
      checkOutput($sformatf("vec%0d_exc", i), 32'(bus.out_exc), 32'(tbl[i].exc));
      checkOutput($sformatf("vec%0d_cnt", i), 32'(exc_count), 32'(tbl[i].cnt));
    end

    // Clear together with an exception leaves the count at one
    applyStimulus(1'b1, 3'd7, 2'd0, MW, RT, 1'b1);
    @(negedge clk);
    checkOutput("clr_with_exc", 32'(exc_count), 32'd1);
    applyStimulus(1'b0, 3'd0, 2'd0, MW, RT, 1'b1);
    @(negedge clk);
    checkOutput("clr_alone", 32'(exc_count), 32'd0);

    // Saturation at 3 for a 2-bit counter
    for (int i = 0; i < 5; i++) begin
      applyStimulus(1'b1, 3'd3, 2'd1, MW, RT, 1'b0);
      @(negedge clk);
      checkOutput($sformatf("sat%0d", i), 32'(exc_count), (i < 3) ? 32'(i + 1) : 32'd3);
    end
    applyStimulus(1'b0, 3'd0, 2'd0, MW, RT, 1'b0);
    @(negedge clk);
    checkOutput("drain_valid", 32'(bus.out_valid), 32'd0);

    // Backpressure: two accepted, third held until the first pop
    bus.out_ready = 1'b0;
    applyStimulus(1'b1, 3'd4, 2'd0, MW, RT, 1'b0);
    @(negedge clk);
    checkOutput("bp_ready1", 32'(bus.in_ready), 32'd1);
    checkOutput("bp_head_a", bus.out_data, 32'h000000F3);
    applyStimulus(1'b1, 3'd4, 2'd1, MW, RT, 1'b0);
    @(negedge clk);
    checkOutput("bp_full", 32'(bus.in_ready), 32'd0);
    applyStimulus(1'b1, 3'd4, 2'd2, MW, RT, 1'b0);
    @(negedge clk);
    checkOutput("bp_held", 32'(bus.in_ready), 32'd0);
    checkOutput("bp_head_still_a", bus.out_data, 32'h000000F3);
    bus.out_ready = 1'b1;
    @(negedge clk);
    checkOutput("bp_head_b", bus.out_data, 32'h000000A2);
    checkOutput("bp_ready_after_pop", 32'(bus.in_ready), 32'd1);
    @(negedge clk);
    applyStimulus(1'b0, 3'd0, 2'd0, MW, RT, 1'b0);
    checkOutput("bp_head_c", bus.out_data, 32'h00000091);
    checkOutput("bp_c_valid", 32'(bus.out_valid), 32'd1);
    @(negedge clk);
    checkOutput("bp_empty", 32'(bus.out_valid), 32'd0);

    // Randomized traffic against the queue model
    mcnt = 3;
    q.delete();
    for (int cyc = 0; cyc < 400; cyc++) begin
      logic [2:0]  rop;
      logic [1:0]  rk;
      logic [31:0] rmw;
      logic [31:0] rrt;
      logic        rv;
      logic        rc;
      checkOutput("rnd_out_valid", 32'(bus.out_valid), 32'(q.size() > 0));
      checkOutput("rnd_in_ready", 32'(bus.in_ready), 32'(q.size() < 2));
      checkOutput("rnd_exc_count", 32'(exc_count), 32'(mcnt));
      if (q.size() > 0) begin
        checkOutput("rnd_out_data", bus.out_data, q[0].data);
        checkOutput("rnd_out_exc", 32'(bus.out_exc), 32'(q[0].exc));
      end
      rop = 3'($urandom_range(0, 7));
      rk  = 2'($urandom_range(0, 3));
      rmw = $urandom;
      rrt = $urandom;
      rv  = ($urandom_range(0, 3) != 0);
      rc  = ($urandom_range(0, 15) == 0);
      bus.out_ready = ($urandom_range(0, 2) != 0);
      applyStimulus(rv, rop, rk, rmw, rrt, rc);
      push = rv && (q.size() < 2);
      pop  = bus.out_ready && (q.size() > 0);
      r    = refFormat(int'(rop), int'(rk), rmw, rrt);
      exc  = r[32];
      if (pop) void'(q.pop_front());
      if (push) q.push_back('{r[31:0], r[32]});
      if (push && exc) mcnt = rc ? 1 : ((mcnt < 3) ? mcnt + 1 : 3);
      else if (rc) mcnt = 0;
      @(negedge clk);
    end

    // Reset mid-stream with two entries buffered
    applyStimulus(1'b0, 3'd0, 2'd0, MW, RT, 1'b0);
    bus.out_ready = 1'b1;
    @(negedge clk);
    @(negedge clk);
    bus.out_ready = 1'b0;
    applyStimulus(1'b1, 3'd7, 2'd0, MW, RT, 1'b0);
    @(negedge clk);
    applyStimulus(1'b1, 3'd3, 2'd0, MW, RT, 1'b0);
    @(negedge clk);
    checkOutput("mid_full", 32'(bus.in_ready), 32'd0);
    applyStimulus(1'b0, 3'd0, 2'd0, MW, RT, 1'b0);
    #1 rst_n = 1'b0;
    #1;
    checkOutput("mid_rst_valid", 32'(bus.out_valid), 32'd0);
    checkOutput("mid_rst_ready", 32'(bus.in_ready), 32'd1);
    checkOutput("mid_rst_cnt", 32'(exc_count), 32'd0);
    #1 rst_n = 1'b1;
    bus.out_ready = 1'b1;
    applyStimulus(1'b1, 3'd5, 2'd2, MW, RT, 1'b0);
    @(negedge clk);
    checkOutput("post_rst_valid", 32'(bus.out_valid), 32'd1);
    checkOutput("post_rst_data", bus.out_data, 32'h00008091);
    applyStimulus(1'b0, 3'd0, 2'd0, MW, RT, 1'b0);
    @(negedge clk);
    checkOutput("post_rst_alone", 32'(bus.out_valid), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/load_extend_unit.md
# load_extend_unit

Parametrised load-data formatter for the MIPS datapath, sitting between data-memory read return and register-file writeback. It extracts byte or halfword lanes, sign- or zero-extends them, and merges LWL/LWR partial words with the old `rt` value. It also flags misaligned or reserved loads and buffers results in a small output FIFO with a valid/ready handshake. It generalises the fixed 8- and 16-bit sign extenders to the full load family, adding buffering and exception counting.

## Interface
- `DEPTH`, default 2: output FIFO entries; power of two, 2..8.
- `CNT_W`, default 16: width of the saturating exception counter.

- `clk` input 1: single clock, rising edge.
- `rst_n` input 1: asynchronous, active-low reset.
- `in_valid` input 1: load response present.
- `in_ready` output 1: FIFO not full; a transfer occurs when `in_valid && in_ready`.
- `op` input 3: low 3 bits of the MIPS load opcode. 0 LB, 1 LH, 2 LWL, 3 LW, 4 LBU, 5 LHU, 6 LWR, 7 reserved.
- `addr_lo` input 2: byte offset within the word.
- `mem_word` input 32: aligned memory word, little-endian; byte k = `mem_word[8k+7:8k]`.
- `rt_old` input 32: current `rt` value, used by LWL/LWR only.
- `out_valid` output 1: FIFO head valid.
- `out_ready` input 1: consumer accepts the head.
- `out_data` output 32: formatted result.
- `out_exc` output 1: head entry was misaligned or reserved.
- `exc_count` output CNT_W: saturating count of accepted exception loads.
- `cnt_clr` input 1: synchronous clear of `exc_count`.

## Operation
- Formatting is combinational on the inputs and written into the FIFO on input handshake. With k = `addr_lo`:
  - LB / LBU: byte k, sign- / zero-extended to 32 bits.
  - LH / LHU: halfword `mem_word[16j+15:16j]` with j = `addr_lo[1]`, sign- / zero-extended. Exception if `addr_lo[0]=1`.
  - LW: `mem_word`. Exception if k≠0.
  - LWL: `(mem_word << 8(3−k)) | (rt_old & ((1<<8(3−k))−1))`. k=3 gives the full word.
  - LWR: `(mem_word >> 8k) | (rt_old & ~(32'hFFFFFFFF >> 8k))`. k=0 gives the full word.
  - op 7: exception.
- On any exception: stored `out_data`=0 and `out_exc`=1. The entry still flows through the FIFO in order; it is never dropped.
- FIFO: DEPTH entries with read/write pointers of log2(DEPTH) bits that wrap modulo DEPTH, plus an occupancy count of log2(DEPTH)+1 bits.
  - Push on input handshake; pop on `out_valid && out_ready`.
  - Simultaneous push and pop leaves the count unchanged.
- Full: `in_ready`=0 regardless of `out_ready`; there is no same-cycle pass-through. Empty: `out_valid`=0, and `out_data`/`out_exc` are don't-care, held at the last head value.
- `exc_count`:
  - Increments on the input handshake of an exception load.
  - Saturates at 2^CNT_W−1.
  - `cnt_clr` alone sets it to 0. `cnt_clr` in the same cycle as an exception handshake sets it to 1.
- Reset (asserted at any time, including mid-stream):
  - Pointers, count and `exc_count` are cleared to 0 immediately.
  - `out_valid`=0, `in_ready`=1 (from count=0), `out_data`=0, `out_exc`=0.
  - All buffered entries are discarded.

## Timing
- Latency: input handshake at edge N → `out_valid`=1 with that result after edge N (visible in cycle N+1).
- Throughput: one load per cycle while not full and the consumer is ready.
- `in_ready` and `out_valid` are derived only from registered count; there are no combinational paths from `in_valid` or `out_ready` to either.
- `out_data`, `out_exc` and `exc_count` are register outputs.
- Deassertion of `rst_n` is synchronised externally; the first handshake is accepted at the first edge with `rst_n`=1.

## Test plan
- Extension, with `mem_word`=0x8091A2F3:
  - LB k=0 → 0xFFFFFFF3
  - LBU k=3 → 0x00000080
  - LH k=2 → 0xFFFF8091
  - LHU k=0 → 0x0000A2F3
  - LW k=0 → 0x8091A2F3
  - All with `out_exc`=0 and latency 1.
- Merge, with `rt_old`=0x11223344 and the same `mem_word`:
  - LWL k=1 → 0xA2F33344
  - LWR k=2 → 0x11228091
  - LWL k=3 and LWR k=0 → 0x8091A2F3
- Exceptions: LH k=1, LW k=2 and op 7 → `out_data`=0, `out_exc`=1, `exc_count` goes 0→1→2→3. Then `cnt_clr` together with one more exception → 1.
- Backpressure, DEPTH=2: hold `out_ready`=0 and stream 3 loads.
  - `in_ready` drops after 2 accepts; the third is held.
  - Release `out_ready` → outputs appear in order, and the third is accepted on the cycle after the first pop.
  - Pointers wrap across 10 loads with no loss.
- Saturation, CNT_W=2: 5 exception loads → `exc_count` reads 1, 2, 3, 3, 3.
- Reset mid-stream: 2 entries buffered, pulse `rst_n` low between edges.
  - Immediately `out_valid`=0, `in_ready`=1, `exc_count`=0.
  - The next load after release emerges alone with the correct data.
